// File: rtl/ysyx_24090013_pkg.sv
// rtl/ysyx_24090013_pkg.sv - shared widths and FSM state type for the regfile dumper
package ysyx_24090013_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_24090013_rf_dumper_if.sv
// rtl/ysyx_24090013_rf_dumper_if.sv - request, regfile read/snoop and entry stream bundle
interface ysyx_24090013_rf_dumper_if;
  import ysyx_24090013_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_all;
  logic [REG_AW-1:0] req_idx;
  logic              rf_ren;
  logic [REG_AW-1:0] rf_raddr;
  logic [XLEN-1:0]   rf_rdata;
  logic              wb_wen;
  logic [REG_AW-1:0] wb_waddr;
  logic [XLEN-1:0]   wb_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] out_idx;
  logic [XLEN-1:0]   out_data;
  logic              out_last;
  logic              done;

  modport slave (
    input  req_valid, req_all, req_idx, rf_rdata, wb_wen, wb_waddr, wb_wdata, out_ready,
    output req_ready, rf_ren, rf_raddr, out_valid, out_idx, out_data, out_last, done
  );

  modport master (
    output req_valid, req_all, req_idx, rf_rdata, wb_wen, wb_waddr, wb_wdata, out_ready,
    input  req_ready, rf_ren, rf_raddr, out_valid, out_idx, out_data, out_last, done
  );

endinterface

// File: rtl/ysyx_24090013_rf_dump_capture.sv
// rtl/ysyx_24090013_rf_dump_capture.sv - entry output register with x0 forcing and optional write bypass
// Optional feature macro: YSYX_24090013_RF_DUMP_BYPASS_EN
module ysyx_24090013_rf_dump_capture
  import ysyx_24090013_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic              cap_last,
  input  logic [REG_AW-1:0] cap_idx,
  input  logic [XLEN-1:0]   rf_rdata,
  input  logic              wb_wen,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [XLEN-1:0]   wb_wdata,
  output logic [REG_AW-1:0] out_idx,
  output logic [XLEN-1:0]   out_data,
  output logic              out_last
);

  logic [XLEN-1:0] sel_data;

`ifdef YSYX_24090013_RF_DUMP_BYPASS_EN
  // Same-cycle writeback wins so the entry shows the post-write architectural value.
  always_comb begin
    sel_data = rf_rdata;
    if (wb_wen && (wb_waddr == cap_idx) && (wb_waddr != '0)) begin
      sel_data = wb_wdata;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = &{1'b0, wb_wen, wb_waddr, wb_wdata};

  always_comb begin
    sel_data = rf_rdata;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_idx  <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (cap_en) begin
      out_idx  <= cap_idx;
      out_data <= (cap_idx == '0) ? '0 : sel_data;
      out_last <= cap_last;
    end
  end

endmodule

// File: rtl/ysyx_24090013_rf_dumper.sv
// rtl/ysyx_24090013_rf_dumper.sv - walks one or all GPRs and streams {index, value} entries
// Optional feature macro: YSYX_24090013_RF_DUMP_BYPASS_EN (see capture sub-module)
module ysyx_24090013_rf_dumper #(
  parameter int NREG = ysyx_24090013_pkg::NREG
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_24090013_rf_dumper_if.slave  bus
);
  import ysyx_24090013_pkg::*;

  state_e            state_q, state_d;
  logic [REG_AW-1:0] idx_q;
  logic              all_q;
  logic              done_q;
  logic              last;
  logic              hs;
  logic              accept;

  // Full mode ends at the top register; the index never advances past it.
  assign last   = !all_q || (idx_q == REG_AW'(NREG - 1));
  assign hs     = (state_q == HOLD) && bus.out_ready;
  assign accept = (state_q == IDLE) && bus.req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = READ;
      READ:    state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = last ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      all_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= hs && last;
      if (accept) begin
        all_q <= bus.req_all;
        idx_q <= bus.req_all ? '0 : bus.req_idx;
      end else if (hs && !last) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.rf_ren    = (state_q == READ);
  assign bus.rf_raddr  = idx_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.done      = done_q;

  ysyx_24090013_rf_dump_capture u_capture (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (state_q == READ),
    .cap_last (last),
    .cap_idx  (idx_q),
    .rf_rdata (bus.rf_rdata),
    .wb_wen   (bus.wb_wen),
    .wb_waddr (bus.wb_waddr),
    .wb_wdata (bus.wb_wdata),
    .out_idx  (bus.out_idx),
    .out_data (bus.out_data),
    .out_last (bus.out_last)
  );

endmodule

// File: tb/tb_ysyx_24090013_rf_dumper.sv
// tb/tb_ysyx_24090013_rf_dumper.sv - self-checking bench for the regfile dumper
module tb_ysyx_24090013_rf_dumper;

`ifdef YSYX_24090013_RF_DUMP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_24090013_rf_dumper_if bus ();

  ysyx_24090013_rf_dumper dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] rf_mem [32];
  assign bus.rf_rdata = rf_mem[bus.rf_raddr];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit        all;
    bit [4:0]  idx;
    bit        rnd_ready;
    int        byp;
    bit [31:0] byp_data;
    int        exp_cnt;
    int        exp_last_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v);
    bit [4:0]  q_idx[$];
    bit [31:0] q_dat[$];
    int n, acc, got, first, last_hs, t;
    bit wrote;
    n = v.all ? 32 : 1;
    for (int k = 0; k < n; k++) begin
      int i;
      bit [31:0] d;
      i = v.all ? k : int'(v.idx);
      d = (i == 0) ? 32'h0 : rf_mem[i];
      if (BYP && v.byp == i && i != 0) d = v.byp_data;
      q_idx.push_back(5'(i));
      q_dat.push_back(d);
    end
    bus.req_all   = v.all;
    bus.req_idx   = v.idx;
    bus.req_valid = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 20) begin
      step();
      t++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 1, 0);
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc;
    step();
    bus.req_valid = 1'b0;
    bus.req_idx   = 5'($urandom);
    got = 0; first = -1; last_hs = -1; t = 0;
    while (got < n && t < 400) begin
      bus.out_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      wrote = 1'b0;
      if (bus.rf_ren && v.byp >= 0 && bus.rf_raddr == 5'(v.byp)) begin
        bus.wb_wen   = 1'b1;
        bus.wb_waddr = 5'(v.byp);
        bus.wb_wdata = v.byp_data;
        wrote = 1'b1;
      end else begin
        bus.wb_wen = 1'b0;
      end
      check("ren_in_hold", bus.rf_ren & bus.out_valid, 0);
      check("done_early", bus.done, 0);
      if (bus.out_valid) begin
        if (first < 0) first = cyc - acc;
        if (bus.out_ready) begin
          check("out_idx", bus.out_idx, q_idx[got]);
          check("out_data", bus.out_data, q_dat[got]);
          check("out_last", bus.out_last, (got == n - 1));
          got++;
          last_hs = cyc - acc;
        end
      end
      step();
      if (wrote) rf_mem[v.byp] = v.byp_data;
      bus.wb_wen = 1'b0;
      t++;
    end
    check("entry_count", got, v.exp_cnt);
    check("done_pulse", bus.done, 1);
    check("first_latency", first, 2);
    if (v.exp_last_lat >= 0) check("last_hs_cycle", last_hs, v.exp_last_lat);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_all = 1'b0; bus.req_idx = '0;
    bus.wb_wen = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 + 32'(i);
    rf_mem[0] = 32'hFFFF_FFFF;
    rf_mem[5] = 32'h1234_5678;

    vecs[0] = '{1'b0, 5'd5,  1'b0, -1, 32'h0,         1,  2};
    vecs[1] = '{1'b1, 5'd0,  1'b0, -1, 32'h0,         32, 64};
    vecs[2] = '{1'b1, 5'd9,  1'b1, -1, 32'h0,         32, -1};
    vecs[3] = '{1'b0, 5'd7,  1'b0,  7, 32'hDEAD_BEEF, 1,  2};
    vecs[4] = '{1'b0, 5'd0,  1'b0,  0, 32'h5555_5555, 1,  2};
    vecs[5] = '{1'b0, 5'd31, 1'b1, -1, 32'h0,         1,  -1};

    step(); step();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_rf_ren", bus.rf_ren, 0);
    check("rst_outputs", {bus.out_idx, bus.out_data, bus.out_last, bus.done, bus.rf_raddr}, 0);
    rst = 1'b0;
    step();
    check("idle_req_ready", bus.req_ready, 1);

    for (int k = 0; k < 6; k++) run_req(vecs[k]);

    // Reset in the middle of a full dump, once entry 10 is presented.
    begin
      int t;
      vec_t fv;
      bus.req_all = 1'b1; bus.req_valid = 1'b1; bus.out_ready = 1'b1;
      step();
      bus.req_valid = 1'b0;
      t = 0;
      while (!(bus.out_valid && bus.out_idx == 5'd10) && t < 100) begin
        step();
        t++;
      end
      check("reach_entry10", bus.out_idx, 10);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_req_ready", bus.req_ready, 0);
      check("midrst_outputs", {bus.out_idx, bus.out_data, bus.out_last, bus.rf_ren, bus.rf_raddr}, 0);
      step();
      check("midrst_done", bus.done, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        check("post_rst_done", bus.done, 0);
        check("post_rst_valid", bus.out_valid, 0);
      end
      fv = '{1'b1, 5'd0, 1'b0, -1, 32'h0, 32, 64};
      run_req(fv);
    end

    // Request held through HOLD is only taken once the dumper is back in IDLE.
    begin
      bus.out_ready = 1'b0;
      bus.req_all = 1'b0; bus.req_idx = 5'd3; bus.req_valid = 1'b1;
      step();
      bus.req_idx = 5'd9;
      step();
      for (int i = 0; i < 4; i++) begin
        check("held_valid", bus.out_valid, 1);
        check("held_req_ready", bus.req_ready, 0);
        check("held_no_ren", bus.rf_ren, 0);
        check("held_idx", bus.out_idx, 3);
        step();
      end
      bus.out_ready = 1'b1;
      step();
      check("b2b_done", bus.done, 1);
      check("b2b_req_ready", bus.req_ready, 1);
      step();
      bus.req_valid = 1'b0;
      check("b2b_ren", bus.rf_ren, 1);
      check("b2b_raddr", bus.rf_raddr, 9);
      step();
      check("b2b_out_idx", bus.out_idx, 9);
      check("b2b_out_data", bus.out_data, rf_mem[9]);
      step();
      check("b2b_done2", bus.done, 1);
    end

    for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
    for (int r = 0; r < 8; r++) begin
      vec_t rv;
      rv.all          = ($urandom_range(0, 3) == 0);
      rv.idx          = 5'($urandom);
      rv.rnd_ready    = 1'($urandom_range(0, 1));
      rv.byp          = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1;
      rv.byp_data     = $urandom;
      rv.exp_cnt      = rv.all ? 32 : 1;
      rv.exp_last_lat = rv.rnd_ready ? -1 : (rv.all ? 64 : 2);
      run_req(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
